// File: rtl/led_pattern_scheduler.sv
// -----------------------------------------------------------------------------
// led_pattern_scheduler
//
// Sequences an 8-LED pattern display. Owns the step-rate prescaler, the pattern
// mode (bounce, rotate left, rotate right, blink) and the run/pause/stop
// control. Host logic issues commands over a valid/ready handshake; the block
// drives the LED bus directly and emits a per-step strobe and an end-of-sweep
// pulse.
//
// Optional feature macro: LED_SWEEP_COUNT_EN
//   When defined, adds the sweep_count output, a saturating count of completed
//   sweeps since the last START load.
//
// Parameters:
//   DIV_WIDTH    width of the step-rate divider and cmd_div
//   DEFAULT_DIV  divider loaded at reset (clock cycles per pattern step)
//
// Ports:
//   clock        system clock, all logic on posedge
//   reset        asynchronous, active-high
//   cmd_valid    command present
//   cmd_ready    command accepted when cmd_valid && cmd_ready
//   cmd_op       0 STOP, 1 START, 2 PAUSE, 3 RESUME
//   cmd_mode     START only: 0 BOUNCE, 1 ROT_L, 2 ROT_R, 3 BLINK
//   cmd_div      START only: cycles per step, 0 treated as 1
//   led          registered LED pattern
//   step         1-cycle pulse on the cycle led changes during a run
//   sweep_done   1-cycle pulse on the step that completes a pattern cycle
//   busy         high in RUN or PAUSE
//   sweep_count  (LED_SWEEP_COUNT_EN only) completed sweeps, saturating
// -----------------------------------------------------------------------------
module led_pattern_scheduler #(
    parameter int          DIV_WIDTH   = 24,
    parameter int unsigned DEFAULT_DIV = 5000000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [1:0]           cmd_mode,
    input  logic [DIV_WIDTH-1:0] cmd_div,
    output logic [7:0]           led,
    output logic                 step,
    output logic                 sweep_done,
    output logic                 busy
`ifdef LED_SWEEP_COUNT_EN
    ,
    output logic [15:0]          sweep_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'd0,
        MODE_ROT_L  = 2'd1,
        MODE_ROT_R  = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    localparam logic [1:0] OP_STOP   = 2'd0;
    localparam logic [1:0] OP_START  = 2'd1;
    localparam logic [1:0] OP_PAUSE  = 2'd2;
    localparam logic [1:0] OP_RESUME = 2'd3;

    // A zero reset divider would make the prescaler compare underflow, so it
    // is promoted to 1 just like a zero cmd_div.
    localparam logic [DIV_WIDTH-1:0] RESET_DIV =
        (DEFAULT_DIV == 0) ? DIV_WIDTH'(1) : DIV_WIDTH'(DEFAULT_DIV);

    state_t               state;
    mode_t                mode;
    logic [DIV_WIDTH-1:0] div_reg;
    logic [DIV_WIDTH-1:0] prescaler;
    logic [2:0]           pos;
    logic                 dir;
    logic                 pending;
    mode_t                pend_mode;
    logic [DIV_WIDTH-1:0] pend_div;

    logic [2:0]           next_pos;
    logic                 next_dir;
    logic                 wrap;

    logic                 accept;
    logic                 op_stop;
    logic                 op_start;
    logic                 op_pause;
    logic                 op_resume;
    logic                 presc_last;
    logic                 run_adv;
    logic                 boundary;
    logic                 load_now;
    logic                 deferred;
    mode_t                load_mode;
    logic [DIV_WIDTH-1:0] load_div;

    // Position that a mode starts from. BLINK uses pos[0] as its phase bit.
    function automatic logic [2:0] start_pos(input mode_t m);
        start_pos = (m == MODE_ROT_R) ? 3'd7 : 3'd0;
    endfunction

    // LED image for a mode/position pair. Non-blink modes are one-hot of pos;
    // blink shows all-on in phase 0 and all-off in phase 1.
    function automatic logic [7:0] pattern(input mode_t m, input logic [2:0] p);
        if (m == MODE_BLINK) begin
            pattern = p[0] ? 8'h00 : 8'hFF;
        end else begin
            pattern = 8'h01 << p;
        end
    endfunction

    // A stored divider is never zero; this keeps the prescaler compare simple.
    function automatic logic [DIV_WIDTH-1:0] eff_div(input logic [DIV_WIDTH-1:0] d);
        eff_div = (d == '0) ? DIV_WIDTH'(1) : d;
    endfunction

    // cmd_ready only drops while a START waits for the next sweep boundary.
    assign cmd_ready = ~pending;

    // Decode the accepted command and the run-time events for this cycle.
    // STOP and PAUSE win over a prescaler wrap landing on the same cycle.
    always_comb begin
        accept     = cmd_valid && cmd_ready;
        op_stop    = accept && (cmd_op == OP_STOP);
        op_start   = accept && (cmd_op == OP_START);
        op_pause   = accept && (cmd_op == OP_PAUSE);
        op_resume  = accept && (cmd_op == OP_RESUME);
        presc_last = (prescaler == (div_reg - DIV_WIDTH'(1)));
        run_adv    = (state == ST_RUN) && presc_last && !op_stop && !op_pause;
        boundary   = run_adv && wrap;
        load_now   = op_start && (state != ST_RUN);
        deferred   = boundary && pending;
        load_mode  = mode_t'(cmd_mode);
        load_div   = eff_div(cmd_div);
    end

    // Next position for the current mode, and whether that move returns the
    // pattern to its start value (the sweep boundary). BOUNCE tracks its
    // direction in dir: up from 0 to 7, then down to 1, then back to 0.
    always_comb begin
        next_pos = pos;
        next_dir = dir;
        wrap     = 1'b0;
        case (mode)
            MODE_BOUNCE: begin
                if (!dir) begin
                    if (pos == 3'd7) begin
                        next_pos = 3'd6;
                        next_dir = 1'b1;
                    end else begin
                        next_pos = pos + 3'd1;
                    end
                end else begin
                    if (pos == 3'd1) begin
                        next_pos = 3'd0;
                        next_dir = 1'b0;
                        wrap     = 1'b1;
                    end else begin
                        next_pos = pos - 3'd1;
                    end
                end
            end
            MODE_ROT_L: begin
                next_pos = pos + 3'd1;
                wrap     = (pos == 3'd7);
            end
            MODE_ROT_R: begin
                next_pos = pos - 3'd1;
                wrap     = (pos == 3'd0);
            end
            default: begin
                next_pos = {2'b00, ~pos[0]};
                wrap     = pos[0];
            end
        endcase
    end

    // Main controller. STOP and immediate START loads take priority over the
    // per-state behaviour. In RUN, a START is parked as pending and swapped in
    // at the next sweep boundary in place of the old mode's start pattern.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            mode       <= MODE_BOUNCE;
            div_reg    <= RESET_DIV;
            prescaler  <= '0;
            pos        <= 3'd0;
            dir        <= 1'b0;
            pending    <= 1'b0;
            pend_mode  <= MODE_BOUNCE;
            pend_div   <= RESET_DIV;
            led        <= 8'h00;
            step       <= 1'b0;
            sweep_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            step       <= 1'b0;
            sweep_done <= 1'b0;
            if (op_stop) begin
                state     <= ST_IDLE;
                busy      <= 1'b0;
                led       <= 8'h00;
                pending   <= 1'b0;
                prescaler <= '0;
            end else if (load_now) begin
                state     <= ST_RUN;
                busy      <= 1'b1;
                mode      <= load_mode;
                div_reg   <= load_div;
                prescaler <= '0;
                pos       <= start_pos(load_mode);
                dir       <= 1'b0;
                led       <= pattern(load_mode, start_pos(load_mode));
            end else begin
                case (state)
                    ST_IDLE: begin
                        led <= 8'h00;
                    end
                    ST_PAUSE: begin
                        if (op_resume) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (op_pause) begin
                            state <= ST_PAUSE;
                        end else begin
                            if (op_start) begin
                                pending   <= 1'b1;
                                pend_mode <= load_mode;
                                pend_div  <= load_div;
                            end
                            if (run_adv) begin
                                prescaler  <= '0;
                                step       <= 1'b1;
                                sweep_done <= wrap;
                                if (deferred) begin
                                    mode    <= pend_mode;
                                    div_reg <= pend_div;
                                    pos     <= start_pos(pend_mode);
                                    dir     <= 1'b0;
                                    led     <= pattern(pend_mode, start_pos(pend_mode));
                                    pending <= 1'b0;
                                end else begin
                                    pos <= next_pos;
                                    dir <= next_dir;
                                    led <= pattern(mode, next_pos);
                                end
                            end else begin
                                prescaler <= prescaler + DIV_WIDTH'(1);
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        led   <= 8'h00;
                    end
                endcase
            end
        end
    end

`ifdef LED_SWEEP_COUNT_EN
    // Completed-sweep counter. Any START load (immediate or deferred) restarts
    // it; a deferred load coincides with a sweep_done, and the clear wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sweep_count <= 16'h0000;
        end else if (load_now || deferred) begin
            sweep_count <= 16'h0000;
        end else if (boundary && (sweep_count != 16'hFFFF)) begin
            sweep_count <= sweep_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_scheduler
//
// Self-checking bench for led_pattern_scheduler. A behavioural model holds
// each mode's LED sequence as an indexed table and counts cycles per step;
// the DUT is compared against it every cycle. Directed scenarios come first,
// followed by a randomized command stream.
// -----------------------------------------------------------------------------
module tb_led_pattern_scheduler;

    localparam int DIV_WIDTH = 24;

    logic                 clock;
    logic                 reset;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [1:0]           cmd_mode;
    logic [DIV_WIDTH-1:0] cmd_div;
    logic [7:0]           led;
    logic                 step;
    logic                 sweep_done;
    logic                 busy;
`ifdef LED_SWEEP_COUNT_EN
    logic [15:0]          sweep_count;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state: 0 idle, 1 run, 2 pause.
    int         m_state;
    int         m_mode;
    int         m_div;
    int         m_idx;
    int         m_elapsed;
    int         m_pmode;
    int         m_pdiv;
    int         m_count;
    bit         m_pending;
    logic [7:0] e_led;
    bit         e_step;
    bit         e_sweep;

    led_pattern_scheduler #(
        .DIV_WIDTH   (DIV_WIDTH),
        .DEFAULT_DIV (5000000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_mode    (cmd_mode),
        .cmd_div     (cmd_div),
        .led         (led),
        .step        (step),
        .sweep_done  (sweep_done),
        .busy        (busy)
`ifdef LED_SWEEP_COUNT_EN
        ,
        .sweep_count (sweep_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int seq_len(input int mode);
        case (mode)
            0:       return 14;
            1, 2:    return 8;
            default: return 2;
        endcase
    endfunction

    // LED value at position idx of a mode's sequence, from the pattern rules.
    function automatic logic [7:0] seq_led(input int mode, input int idx);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = 8'h01;
        hi = 8'h80;
        case (mode)
            0:       return (idx <= 7) ? (lo << idx) : (lo << (14 - idx));
            1:       return lo << idx;
            2:       return hi >> idx;
            default: return (idx == 0) ? 8'hFF : 8'h00;
        endcase
    endfunction

    task automatic modelReset();
        m_state   = 0;
        m_mode    = 0;
        m_div     = 5000000;
        m_idx     = 0;
        m_elapsed = 0;
        m_pmode   = 0;
        m_pdiv    = 1;
        m_count   = 0;
        m_pending = 1'b0;
        e_led     = 8'h00;
        e_step    = 1'b0;
        e_sweep   = 1'b0;
    endtask

    task automatic modelLoad(input int mode, input int div);
        m_state   = 1;
        m_mode    = mode;
        m_div     = (div == 0) ? 1 : div;
        m_idx     = 0;
        m_elapsed = 0;
        m_count   = 0;
        e_led     = seq_led(mode, 0);
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic modelTick();
        bit acc;
        bit new_pend;
        int op;
        acc      = cmd_valid && !m_pending;
        op       = int'(cmd_op);
        new_pend = 1'b0;
        e_step   = 1'b0;
        e_sweep  = 1'b0;
        if (acc && op == 0) begin
            m_state   = 0;
            m_pending = 1'b0;
            m_elapsed = 0;
            e_led     = 8'h00;
        end else if (m_state != 1) begin
            if (acc && op == 1) begin
                modelLoad(int'(cmd_mode), int'(cmd_div));
            end else if (m_state == 2 && acc && op == 3) begin
                m_state = 1;
            end
        end else if (acc && op == 2) begin
            m_state = 2;
        end else begin
            if (acc && op == 1) begin
                new_pend = 1'b1;
                m_pmode  = int'(cmd_mode);
                m_pdiv   = (cmd_div == 0) ? 1 : int'(cmd_div);
            end
            m_elapsed++;
            if (m_elapsed >= m_div) begin
                m_elapsed = 0;
                e_step    = 1'b1;
                m_idx     = (m_idx + 1) % seq_len(m_mode);
                if (m_idx == 0) begin
                    e_sweep = 1'b1;
                    if (m_pending) begin
                        m_mode    = m_pmode;
                        m_div     = m_pdiv;
                        m_pending = 1'b0;
                        m_count   = 0;
                    end else if (m_count < 65535) begin
                        m_count++;
                    end
                end
                e_led = seq_led(m_mode, m_idx);
            end
            if (new_pend) m_pending = 1'b1;
        end
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (led === e_led) else begin
            errors++;
            $error("[TB] FAIL %s led: got %h expected %h", tag, led, e_led);
        end
        checks++;
        assert (step === e_step) else begin
            errors++;
            $error("[TB] FAIL %s step: got %b expected %b", tag, step, e_step);
        end
        checks++;
        assert (sweep_done === e_sweep) else begin
            errors++;
            $error("[TB] FAIL %s sweep_done: got %b expected %b", tag, sweep_done, e_sweep);
        end
        checks++;
        assert (busy === (m_state != 0)) else begin
            errors++;
            $error("[TB] FAIL %s busy: got %b expected %b", tag, busy, (m_state != 0));
        end
        checks++;
        assert (cmd_ready === !m_pending) else begin
            errors++;
            $error("[TB] FAIL %s cmd_ready: got %b expected %b", tag, cmd_ready, !m_pending);
        end
`ifdef LED_SWEEP_COUNT_EN
        checks++;
        assert (sweep_count === 16'(m_count)) else begin
            errors++;
            $error("[TB] FAIL %s sweep_count: got %0d expected %0d", tag, sweep_count, m_count);
        end
`endif
    endtask

    task automatic cycle(input string tag);
        modelTick();
        @(posedge clock);
        #1;
        checkOutput(tag);
    endtask

    // Drive one command for one cycle, then drop valid.
    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] mode,
                                 input int div, input string tag);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mode  = mode;
        cmd_div   = DIV_WIDTH'(div);
        cycle(tag);
        cmd_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    // Run until the DUT shows target on led, bounded by budget cycles.
    task automatic runUntilLed(input logic [7:0] target, input int budget, input string tag);
        int n;
        n = 0;
        while (led !== target && n < budget) begin
            cycle(tag);
            n++;
        end
        checks++;
        assert (led === target) else begin
            errors++;
            $error("[TB] FAIL %s wait led: got %h expected %h", tag, led, target);
        end
    endtask

    initial begin
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_mode  = 2'd0;
        cmd_div   = '0;
        reset     = 1'b0;
        modelReset();
        #1 reset = 1'b1;
        #1 checkOutput("reset");
        #10 reset = 1'b0;
        @(posedge clock);
        #1 checkOutput("reset_release");

        // Bounce at div 2: two full sweeps.
        applyStimulus(2'd1, 2'd0, 2, "bounce_start");
        idleCycles(60, "bounce_run");

        // Rotate right at div 0: a step every cycle.
        applyStimulus(2'd0, 2'd0, 0, "stop1");
        applyStimulus(2'd1, 2'd2, 0, "rotr_start");
        idleCycles(20, "rotr_run");

        // Pause mid-step in bounce div 3, then resume.
        applyStimulus(2'd0, 2'd0, 0, "stop2");
        applyStimulus(2'd1, 2'd0, 3, "bounce3_start");
        runUntilLed(8'h10, 40, "bounce3_seek");
        cycle("bounce3_mid");
        applyStimulus(2'd2, 2'd0, 0, "pause");
        idleCycles(20, "paused");
        applyStimulus(2'd3, 2'd0, 0, "resume");
        idleCycles(10, "resumed");

        // Deferred START from rotate left div 1 into blink div 2.
        applyStimulus(2'd0, 2'd0, 0, "stop3");
        applyStimulus(2'd1, 2'd1, 1, "rotl_start");
        runUntilLed(8'h04, 20, "rotl_seek");
        applyStimulus(2'd1, 2'd3, 2, "blink_pending");
        idleCycles(12, "blink_run");

        // STOP from run, then RESUME in IDLE is ignored.
        applyStimulus(2'd0, 2'd0, 0, "stop_run");
        applyStimulus(2'd3, 2'd0, 0, "resume_idle");
        idleCycles(4, "idle_hold");

        // Rotate left div 1 for three sweeps, then restart.
        applyStimulus(2'd1, 2'd1, 1, "count_start");
        idleCycles(24, "count_run");
        applyStimulus(2'd0, 2'd0, 0, "count_stop");
        applyStimulus(2'd1, 2'd3, 1, "count_restart");
        idleCycles(3, "count_after");

        // Asynchronous reset between clock edges.
        #3 reset = 1'b1;
        #1 modelReset();
        checkOutput("async_reset");
        @(posedge clock);
        #1 checkOutput("async_reset_hold");
        #3 reset = 1'b0;
        idleCycles(2, "post_reset");

        // Randomized command stream.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 20) begin
                int r;
                logic [1:0] op;
                r = int'($urandom_range(0, 9));
                if (r == 0)      op = 2'd0;
                else if (r <= 4) op = 2'd1;
                else if (r <= 6) op = 2'd2;
                else             op = 2'd3;
                applyStimulus(op, 2'($urandom_range(0, 3)),
                              int'($urandom_range(0, 4)), "random");
            end else begin
                cycle("random_idle");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
